// File: rtl/uart_tx_fifo_gen2_if.sv
// Word handshake between the register/bus side and the UART transmitter FIFO.
interface uart_tx_fifo_gen2_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  Data_Ready;

   modport master (output P_DATA, output Data_Valid, input Data_Ready);
   modport slave  (input P_DATA, input Data_Valid, output Data_Ready);
endinterface

// File: rtl/uart_tx_fifo_gen2.sv
// Async-framed UART transmitter with an input FIFO, runtime prescaler, optional
// parity and one or two stop bits; frames are sent back-to-back while words are queued.
module uart_tx_fifo_gen2 #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int PRESC_WIDTH = 16
) (
   input  logic                          CLK,
   input  logic                          RST,
   uart_tx_fifo_gen2_if.slave            bus,
   input  logic                          PAR_EN,
   input  logic                          PAR_TYP,
   input  logic                          STOP2,
   input  logic [PRESC_WIDTH-1:0]        PRESCALE,
   output logic                          Busy,
   output logic                          TX_OUT,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
   output logic                          Frame_Done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP_2} state_t;

   logic [DATA_WIDTH-1:0]  fifoMem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]       count_q, count_d;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       bitIdx_q, bitIdx_d;
   logic [PRESC_WIDTH-1:0] baudCnt_q, baudCnt_d;
   logic [PRESC_WIDTH-1:0] presc_q, presc_d;
   logic [DATA_WIDTH-1:0]  shadow_q, shadow_d;
   logic                   parEn_q, parEn_d;
   logic                   parTyp_q, parTyp_d;
   logic                   stop2_q, stop2_d;
   logic                   txOut_q, txOut_d;
   logic                   frameDone_q, frameDone_d;

   logic                   push, pop, frameEnd, bitEnd;
   logic [PRESC_WIDTH-1:0] prescEff;

   assign bus.Data_Ready = (count_q != FULL_CNT);
   assign push           = bus.Data_Valid && bus.Data_Ready;
   assign bitEnd         = (baudCnt_q == '0);
   assign prescEff       = (PRESCALE == '0) ? PRESC_WIDTH'(1) : PRESCALE;

   assign Busy       = (state_q != IDLE) || (count_q != '0);
   assign TX_OUT     = txOut_q;
   assign FIFO_COUNT = count_q;
   assign Frame_Done = frameDone_q;

   always_comb begin
      wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
      rdPtr_d = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      bitIdx_d    = bitIdx_q;
      baudCnt_d   = baudCnt_q;
      presc_d     = presc_q;
      shadow_d    = shadow_q;
      parEn_d     = parEn_q;
      parTyp_d    = parTyp_q;
      stop2_d     = stop2_q;
      frameDone_d = 1'b0;
      frameEnd    = 1'b0;
      pop         = 1'b0;
      txOut_d     = 1'b1;

      if (state_q != IDLE) begin
         if (!bitEnd) begin
            baudCnt_d = baudCnt_q - PRESC_WIDTH'(1);
         end else begin
            baudCnt_d = presc_q - PRESC_WIDTH'(1);
            case (state_q)
               START: begin
                  state_d  = DATA;
                  bitIdx_d = '0;
               end
               DATA: begin
                  if (bitIdx_q == LAST_IDX) state_d = parEn_q ? PARITY : STOP1;
                  else                      bitIdx_d = bitIdx_q + IDX_W'(1);
               end
               PARITY:  state_d = STOP1;
               STOP1: begin
                  if (stop2_q) state_d = STOP_2;
                  else         frameEnd = 1'b1;
               end
               STOP_2:  frameEnd = 1'b1;
               default: state_d = IDLE;
            endcase
         end
      end

      if (frameEnd) begin
         frameDone_d = 1'b1;
         state_d     = IDLE;
      end

      // A queued word starts its frame on the same edge the previous one ends.
      if ((state_q == IDLE || frameEnd) && count_q != '0) begin
         pop       = 1'b1;
         shadow_d  = fifoMem_q[rdPtr_q];
         parEn_d   = PAR_EN;
         parTyp_d  = PAR_TYP;
         stop2_d   = STOP2;
         presc_d   = prescEff;
         baudCnt_d = prescEff - PRESC_WIDTH'(1);
         state_d   = START;
      end

      case (state_d)
         START:   txOut_d = 1'b0;
         DATA:    txOut_d = shadow_q[bitIdx_d];
         PARITY:  txOut_d = (^shadow_q) ^ parTyp_q;
         default: txOut_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST && push) fifoMem_q[wrPtr_q] <= bus.P_DATA;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         state_q     <= IDLE;
         bitIdx_q    <= '0;
         baudCnt_q   <= '0;
         presc_q     <= PRESC_WIDTH'(1);
         shadow_q    <= '0;
         parEn_q     <= 1'b0;
         parTyp_q    <= 1'b0;
         stop2_q     <= 1'b0;
         txOut_q     <= 1'b1;
         frameDone_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         bitIdx_q    <= bitIdx_d;
         baudCnt_q   <= baudCnt_d;
         presc_q     <= presc_d;
         shadow_q    <= shadow_d;
         parEn_q     <= parEn_d;
         parTyp_q    <= parTyp_d;
         stop2_q     <= stop2_d;
         txOut_q     <= txOut_d;
         frameDone_q <= frameDone_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_gen2.sv
// Bench for uart_tx_fifo_gen2: a line monitor decodes every frame against a scoreboard of
// queued words, while table vectors and hand-written sequences check timing, FIFO and reset.
module tb_uart_tx_fifo_gen2;

   localparam int DW = 8;
   localparam int FD = 4;
   localparam int PW = 16;

   logic                 CLK;
   logic                 RST;
   logic                 PAR_EN, PAR_TYP, STOP2;
   logic [PW-1:0]        PRESCALE;
   logic                 Busy, TX_OUT, Frame_Done;
   logic [$clog2(FD):0]  FIFO_COUNT;

   uart_tx_fifo_gen2_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx_fifo_gen2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .PRESC_WIDTH(PW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .bus        (bus),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP2      (STOP2),
      .PRESCALE   (PRESCALE),
      .Busy       (Busy),
      .TX_OUT     (TX_OUT),
      .FIFO_COUNT (FIFO_COUNT),
      .Frame_Done (Frame_Done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [DW-1:0] data;
      logic          parEn;
      logic          parTyp;
      logic          stop2;
      logic [PW-1:0] presc;
   } frame_t;

   typedef struct {
      frame_t cfg;
      logic   expPar;
      int     expLen;
   } vector_t;

   frame_t  sbQ[$];
   vector_t vecs[6];
   int      checks = 0;
   int      errors = 0;
   int      doneCount = 0;
   logic    monParity;

   function automatic frame_t mkFrame(input logic [DW-1:0] d, input logic pe, input logic pt,
                                      input logic s2, input logic [PW-1:0] p);
      frame_t f;
      f.data = d; f.parEn = pe; f.parTyp = pt; f.stop2 = s2; f.presc = p;
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Drives one word for one edge with its frame config and records the expected frame.
   task automatic applyStimulus(input frame_t f);
      PAR_EN         = f.parEn;
      PAR_TYP        = f.parTyp;
      STOP2          = f.stop2;
      PRESCALE       = f.presc;
      bus.P_DATA     = f.data;
      bus.Data_Valid = 1'b1;
      sbQ.push_back(f);
      @(posedge CLK);
      #1;
      bus.Data_Valid = 1'b0;
   endtask

   task automatic waitDone(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (doneCount < target && n < budget) begin
         @(negedge CLK);
         n++;
      end
      checkOutput(name, 32'(doneCount), 32'(target));
   endtask

   always @(negedge CLK) if (Frame_Done === 1'b1) doneCount++;

   task automatic readBit(input int p, input bit first, output logic v, inout bit bad, output bit aborted);
      aborted = 1'b0;
      v = 1'bx;
      for (int k = 0; k < p; k++) begin
         if (!(first && k == 0)) @(negedge CLK);
         if (RST === 1'b1) begin
            aborted = 1'b1;
            return;
         end
         if (k == 0) v = TX_OUT;
         else if (TX_OUT !== v) bad = 1'b1;
      end
   endtask

   task automatic decodeFrame(output bit nextStart);
      frame_t        e;
      int            p;
      logic [DW-1:0] got;
      logic          v;
      bit            bad, ab, stopOk;
      nextStart = 1'b0;
      bad = 1'b0;
      stopOk = 1'b1;
      got = '0;
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected_frame: got start bit, required idle line");
         return;
      end
      e = sbQ.pop_front();
      p = (e.presc == '0) ? 1 : int'(e.presc);
      readBit(p, 1'b1, v, bad, ab);
      if (ab) return;
      for (int i = 0; i < DW; i++) begin
         readBit(p, 1'b0, v, bad, ab);
         if (ab) return;
         got[i] = v;
      end
      if (e.parEn) begin
         readBit(p, 1'b0, v, bad, ab);
         if (ab) return;
         monParity = v;
         checkOutput("parity_bit", 32'(v), 32'((^e.data) ^ e.parTyp));
      end
      readBit(p, 1'b0, v, bad, ab);
      if (ab) return;
      if (v !== 1'b1) stopOk = 1'b0;
      if (e.stop2) begin
         readBit(p, 1'b0, v, bad, ab);
         if (ab) return;
         if (v !== 1'b1) stopOk = 1'b0;
      end
      checkOutput("frame_data", 32'(got), 32'(e.data));
      checkOutput("bit_timing_glitch", 32'(bad), 32'd0);
      checkOutput("stop_bits", 32'(stopOk), 32'd1);
      @(negedge CLK);
      if (RST === 1'b1) return;
      checkOutput("frame_done_pulse", 32'(Frame_Done), 32'd1);
      nextStart = (TX_OUT === 1'b0);
      if (sbQ.size() != 0) checkOutput("back_to_back_start", 32'(nextStart), 32'd1);
   endtask

   initial begin
      bit ns;
      ns = 1'b0;
      forever begin
         if (!ns) @(negedge CLK);
         if (RST === 1'b0 && TX_OUT === 1'b0) decodeFrame(ns);
         else ns = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   n, startDone, doneBefore;
      bit   found, sawLow;
      logic [DW-1:0] words [6];

      RST = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = '0;
      bus.P_DATA = '0; bus.Data_Valid = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checkOutput("reset_tx_out", 32'(TX_OUT), 32'd1);
      checkOutput("reset_busy", 32'(Busy), 32'd0);
      checkOutput("reset_data_ready", 32'(bus.Data_Ready), 32'd1);
      checkOutput("reset_fifo_count", 32'(FIFO_COUNT), 32'd0);
      RST = 1'b0;

      vecs[0] = '{cfg: mkFrame(8'hA5, 1'b1, 1'b0, 1'b0, 16'd4), expPar: 1'b0, expLen: 44};
      vecs[1] = '{cfg: mkFrame(8'hA5, 1'b1, 1'b1, 1'b0, 16'd4), expPar: 1'b1, expLen: 44};
      vecs[2] = '{cfg: mkFrame(8'hA5, 1'b0, 1'b0, 1'b1, 16'd0), expPar: 1'b0, expLen: 11};
      vecs[3] = '{cfg: mkFrame(8'h3C, 1'b1, 1'b0, 1'b1, 16'd3), expPar: 1'b0, expLen: 36};
      vecs[4] = '{cfg: mkFrame(8'h01, 1'b1, 1'b0, 1'b0, 16'd1), expPar: 1'b1, expLen: 11};
      vecs[5] = '{cfg: mkFrame(8'hFF, 1'b1, 1'b1, 1'b0, 16'd2), expPar: 1'b1, expLen: 22};

      for (int i = 0; i < 6; i++) begin
         repeat (2) @(posedge CLK);
         #1;
         checkOutput($sformatf("ready_before_send_v%0d", i), 32'(bus.Data_Ready), 32'd1);
         applyStimulus(vecs[i].cfg);
         n = 0;
         found = 1'b0;
         while (n < vecs[i].expLen + 20 && !found) begin
            @(negedge CLK);
            n++;
            if (n == 1) checkOutput($sformatf("busy_after_accept_v%0d", i), 32'(Busy), 32'd1);
            if (Frame_Done === 1'b1) found = 1'b1;
         end
         checkOutput($sformatf("done_latency_v%0d", i), found ? 32'(n) : 32'hFFFF_FFFF,
                     32'(vecs[i].expLen + 2));
         checkOutput($sformatf("busy_after_frame_v%0d", i), 32'(Busy), 32'd0);
         checkOutput($sformatf("tx_idle_after_frame_v%0d", i), 32'(TX_OUT), 32'd1);
         if (vecs[i].cfg.parEn)
            checkOutput($sformatf("table_parity_v%0d", i), 32'(monParity), 32'(vecs[i].expPar));
      end

      // FIFO fill with Data_Valid held high: five words fit, the sixth waits.
      repeat (3) @(posedge CLK);
      #1;
      words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      PRESCALE = 16'd2; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
      startDone = doneCount;
      bus.Data_Valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.P_DATA = words[i];
         sbQ.push_back(mkFrame(words[i], 1'b0, 1'b0, 1'b0, 16'd2));
         @(posedge CLK);
         #1;
      end
      checkOutput("fifo_full_count", 32'(FIFO_COUNT), 32'd4);
      checkOutput("fifo_full_ready_low", 32'(bus.Data_Ready), 32'd0);
      bus.P_DATA = words[5];
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("fifo_full_no_overwrite", 32'(FIFO_COUNT), 32'd4);
      bus.Data_Valid = 1'b0;
      waitDone(startDone + 5, 5 * 20 + 60, "fifo_five_frames");
      checkOutput("fifo_scoreboard_drained", 32'(sbQ.size()), 32'd0);
      checkOutput("fifo_busy_after_drain", 32'(Busy), 32'd0);

      // Config changed mid-frame applies only to the next frame.
      repeat (2) @(posedge CLK);
      #1;
      startDone = doneCount;
      applyStimulus(mkFrame(8'h5A, 1'b0, 1'b0, 1'b0, 16'd4));
      repeat (10) @(posedge CLK);
      #1;
      PRESCALE = 16'd8;
      PAR_EN = 1'b1;
      applyStimulus(mkFrame(8'hC3, 1'b1, 1'b0, 1'b0, 16'd8));
      waitDone(startDone + 2, 40 + 88 + 40, "midframe_cfg_two_frames");
      checkOutput("midframe_scoreboard_drained", 32'(sbQ.size()), 32'd0);

      // Reset during the data bits of the second of three queued frames.
      repeat (2) @(posedge CLK);
      #1;
      PRESCALE = 16'd2; PAR_EN = 1'b0; STOP2 = 1'b0;
      startDone = doneCount;
      bus.Data_Valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.P_DATA = words[i] ^ 8'hF0;
         sbQ.push_back(mkFrame(words[i] ^ 8'hF0, 1'b0, 1'b0, 1'b0, 16'd2));
         @(posedge CLK);
         #1;
      end
      bus.Data_Valid = 1'b0;
      waitDone(startDone + 1, 60, "reset_first_frame_done");
      repeat (5) @(posedge CLK);
      #1;
      doneBefore = doneCount;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      sbQ.delete();
      checkOutput("midframe_reset_tx_out", 32'(TX_OUT), 32'd1);
      checkOutput("midframe_reset_fifo_count", 32'(FIFO_COUNT), 32'd0);
      checkOutput("midframe_reset_busy", 32'(Busy), 32'd0);
      sawLow = 1'b0;
      repeat (100) begin
         @(negedge CLK);
         if (TX_OUT !== 1'b1) sawLow = 1'b1;
      end
      checkOutput("no_frames_after_reset", 32'(sawLow), 32'd0);
      checkOutput("no_done_after_reset", 32'(doneCount), 32'(doneBefore));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_gen2.md
Name: uart_tx_fifo_gen2

Overview:
Parametrised successor UART transmitter. It serialises DATA_WIDTH-bit words onto TX_OUT in standard async framing: start bit, LSB-first data, optional even/odd parity, then 1 or 2 stop bits. A FIFO_DEPTH-entry input FIFO with a valid/ready handshake is included, along with a runtime baud prescaler. Frames go out back-to-back. The block sits between the register/bus side and the serial pin, replacing the single-word, fixed-rate transmitter.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..16)
FIFO_DEPTH, 4, input FIFO entries (power of 2, >= 2)
PRESC_WIDTH, 16, width of PRESCALE input

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  word to transmit
Data_Valid  input  1  P_DATA valid; word accepted on an edge where Data_Valid && Data_Ready
Data_Ready  output  1  FIFO can accept a word
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  0 = one stop bit, 1 = two stop bits
PRESCALE  input  PRESC_WIDTH  clocks per bit; 0 treated as 1
Busy  output  1  high while a frame is in progress or the FIFO is non-empty
TX_OUT  output  1  serial line, idle high
FIFO_COUNT  output  $clog2(FIFO_DEPTH)+1  entries currently held
Frame_Done  output  1  one-cycle pulse at the end of each frame's last stop bit

Behaviour:
- Reset (synchronous, RST=1 at an edge):
  - State = IDLE; FIFO flushed; FIFO_COUNT = 0.
  - TX_OUT = 1, Busy = 0, Data_Ready = 1, Frame_Done = 0.
  - Reset mid-frame aborts the frame. TX_OUT is 1 from the reset edge onward, and no Frame_Done is produced.
- FIFO:
  - Data_Ready = (FIFO_COUNT != FIFO_DEPTH), derived from registered count.
  - Push and pop on the same edge leave the count unchanged.
  - Pop occurs only from a non-empty FIFO as registered before the edge. A word pushed at edge E can be popped at E+1 at the earliest.
  - Pointers wrap modulo FIFO_DEPTH.
  - When full, Data_Valid is ignored; no overwrite, no error flag.
- Busy = (state != IDLE) || (FIFO_COUNT != 0).
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP_2.
  - IDLE: TX_OUT = 1. If FIFO non-empty, at the edge: pop the word, latch word/PAR_EN/PAR_TYP/STOP2/PRESCALE into a frame shadow, enter START.
  - Config inputs are sampled only at that edge. Changes mid-frame take effect on the next frame.
  - START: TX_OUT = 0 for one bit time, then DATA.
  - DATA: TX_OUT = shadow[bit_idx], bit_idx 0..DATA_WIDTH-1, one bit time each. After the last bit, go to PARITY if PAR_EN, else STOP1.
  - PARITY: TX_OUT = ^data (even) or ~^data (odd); then STOP1.
  - STOP1: TX_OUT = 1; then STOP_2 if STOP2 latched, else end of frame.
  - STOP_2: TX_OUT = 1; then end of frame.
- Bit time: exactly max(PRESCALE,1) clocks per bit, using a down-counter reloaded at each bit boundary from the latched value.
- End of frame: Frame_Done = 1 for the cycle following the frame-ending edge.
  - If the FIFO is non-empty at that edge: pop, latch, and go directly to START with no idle gap.
  - Otherwise go to IDLE.
- Latency: a word accepted at edge E into an empty FIFO with FSM in IDLE is popped at E+1. TX_OUT falls to 0 after E+1.
- Frame length in clocks = P*(1 + DATA_WIDTH + PAR_EN + 1 + STOP2), where P = max(PRESCALE,1).
- All outputs are registered except Data_Ready and Busy, which are decoded from registered state/count.

Test Plan:
1. Reset with RST=1 for 2 clocks, all inputs 0 -> TX_OUT=1, Busy=0, Data_Ready=1, FIFO_COUNT=0.
2. DATA_WIDTH=8, PRESCALE=4, PAR_EN=1, PAR_TYP=0, STOP2=0, send 0xA5 -> TX_OUT bits 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 4 clocks, 44 clocks total; Frame_Done one pulse; Busy drops to 0 on the following edge.
3. Same word with PAR_TYP=1 -> parity bit 1. With PAR_EN=0, STOP2=1, PRESCALE=0 -> 11 bits of 1 clock each, no parity bit, two stop bits.
4. FIFO_DEPTH=4, PRESCALE=2, Data_Valid held high with 6 distinct words -> 5 accepted on 5 consecutive edges; Data_Ready low once FIFO_COUNT=4; 5 frames back-to-back with no idle cycle between stop and start; 5 Frame_Done pulses; words in order.
5. Change PRESCALE 4->8 and PAR_EN 0->1 mid-frame -> current frame keeps 4 clocks/bit and no parity; the next frame uses 8 clocks/bit with parity.
6. Assert RST during the DATA state of the second of 3 queued frames -> TX_OUT=1 and FIFO_COUNT=0 after the reset edge; no Frame_Done; no further frames sent.
